// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: pops through rd_en/empty/data, absorbs read latency
// in a 3-entry prefetch buffer, and presents a registered valid/ready stream. Option: FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int unsigned Data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [Data_width-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Data_width-1:0] m_data,
  output logic [1:0]            occupancy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]           word_count
`endif
);

  localparam int unsigned Depth = 3;
  localparam int unsigned PtrW  = 2;
  localparam int unsigned SumW  = 3;

  logic [Data_width-1:0] mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [1:0]            occ_d;
  logic                  inflight_q;
  logic [SumW-1:0]       pending_c;
  logic                  capture_c, pop_c, valid_d;
  logic [Data_width-1:0] head_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Issue, capture/pop and next-state of the output register
  always_comb begin
    pending_c  = SumW'(occupancy) + SumW'(inflight_q);
    fifo_rd_en = !rst && !fifo_empty && (pending_c <= SumW'(2));
    capture_c  = inflight_q;
    pop_c      = m_valid && m_ready;
    wr_ptr_d   = capture_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d      = occupancy;
    if (capture_c && !pop_c) occ_d = occupancy + 2'd1;
    else if (!capture_c && pop_c) occ_d = occupancy - 2'd1;
    valid_d = (occ_d != 2'd0);
    // A word landing in the slot that becomes the head bypasses the buffer
    head_d = (capture_c && (wr_ptr_q == rd_ptr_d)) ? fifo_rd_data : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occupancy  <= '0;
      inflight_q <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      if (capture_c) mem_q[wr_ptr_q] <= fifo_rd_data;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occupancy  <= occ_d;
      inflight_q <= fifo_rd_en;
      m_valid    <= valid_d;
      m_data     <= head_d;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  // Accepted-word counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (rst) word_count <= '0;
    else if (pop_c) word_count <= word_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural FIFO model feeding the DUT, scoreboard of
// expected words compared on each accepted transfer.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold_empty = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]   word_count;
`endif

  logic [DW-1:0] mem [0:255];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic          tb_inflight = 1'b0;
  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;

  fifo_rd_stream #(.Data_width(DW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .occupancy(occupancy)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO read port: one-cycle read latency
  assign fifo_empty = hold_empty || (wr_cnt == rd_cnt);
  always @(posedge clk) begin
    tb_inflight <= fifo_rd_en;
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[8'(rd_cnt)];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic push_word(input logic [DW-1:0] w, input bit expect_out);
    mem[8'(wr_cnt)] = w;
    wr_cnt = wr_cnt + 1;
    if (expect_out) exp_q.push_back(w);
  endtask

  // Leaves rst asserted, FIFO flushed and scoreboard empty, at a negedge
  task automatic do_reset();
    rst = 1'b1;
    hold_empty = 1'b1;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    wr_cnt = rd_cnt;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold_empty = 1'b0;
    m_ready = 1'b1;
    push_word(8'hE1, 1'b0);
    push_word(8'hE2, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", m_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] w;
    do_reset();
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    hold_empty = 1'b0;
    m_ready = 1'b1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (cyc == 0) begin
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL basic_first_rd: got %b expected 1", fifo_rd_en); end
      end
      checks++;
      if (m_valid !== (cyc >= 2 && cyc <= 4)) begin
        errors++; $display("FAIL basic_valid_c%0d: got %b expected %b", cyc, m_valid, (cyc >= 2 && cyc <= 4));
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra: got %0h expected none", m_data); end
        else begin w = exp_q.pop_front(); if (m_data !== w) begin errors++; $display("FAIL basic_data: got %0h expected %0h", m_data, w); end end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d words left expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'(8'hA0 + i), 1'b1);
    hold_empty = 1'b0;
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      checks++;
      if (3'(occupancy) + 3'(tb_inflight) > 3'd3) begin
        errors++; $display("FAIL bp_overflow: got occ %0d inflight %b expected sum <= 3", occupancy, tb_inflight);
      end
      if (m_valid) begin
        checks++; if (m_data !== exp_q[0]) begin errors++; $display("FAIL bp_stable: got %0h expected %0h", m_data, exp_q[0]); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL bp_occ: got %0d expected 3", occupancy); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b expected 0", fifo_rd_en); end
    @(negedge clk);
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
      #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_gap_c%0d: got %b expected 1", cyc, m_valid); end
      if (m_valid && m_ready) begin
        checks++;
        w = exp_q.pop_front();
        if (m_data !== w) begin errors++; $display("FAIL bp_data: got %0h expected %0h", m_data, w); end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: got %0d words left expected 0", exp_q.size()); end
  endtask

  task automatic test_toggle();
    logic [DW-1:0] w;
    do_reset();
    for (int i = 0; i < 10; i++) push_word(8'(i), 1'b1);
    hold_empty = 1'b0;
    rst = 1'b0;
    for (int cyc = 0; cyc < 60 && exp_q.size() != 0; cyc++) begin
      m_ready = (cyc % 2 == 0);
      #1;
      if (m_valid && m_ready) begin
        checks++;
        w = exp_q.pop_front();
        if (m_data !== w) begin errors++; $display("FAIL toggle_data: got %0h expected %0h", m_data, w); end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL toggle_timeout: got %0d words left expected 0", exp_q.size()); end
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL toggle_dup: got valid %b data %0h expected 0", m_valid, m_data); end
  endtask

  task automatic test_empty_rise();
    logic [DW-1:0] w;
    do_reset();
    push_word(8'hA5, 1'b1);
    push_word(8'h5A, 1'b0);
    m_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    hold_empty = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL er_issue: got %b expected 1", fifo_rd_en); end
    @(negedge clk);
    hold_empty = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL er_extra_rd: got %b expected 0", fifo_rd_en); end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL er_extra_word: got %0h expected none", m_data); end
        else begin w = exp_q.pop_front(); if (m_data !== w) begin errors++; $display("FAIL er_data: got %0h expected %0h", m_data, w); end end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL er_lost: got %0d words left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    do_reset();
    for (int i = 0; i < 10; i++) push_word(8'(8'hC0 + i), 1'b0);
    hold_empty = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rm_occ_pre: got %0d expected 2", occupancy); end
    checks++; if (tb_inflight !== 1'b1) begin errors++; $display("FAIL rm_inflight: got %b expected 1", tb_inflight); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", m_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rm_occ: got %0d expected 0", occupancy); end
    hold_empty = 1'b1;
    wr_cnt = rd_cnt;
    push_word(8'h77, 1'b1);
    push_word(8'h78, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    hold_empty = 1'b0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rm_extra: got %0h expected none", m_data); end
        else begin w = exp_q.pop_front(); if (m_data !== w) begin errors++; $display("FAIL rm_data: got %0h expected %0h", m_data, w); end end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_timeout: got %0d words left expected 0", exp_q.size()); end
  endtask

`ifdef FIFO_RD_STREAM_CNT_EN
  task automatic test_count();
    int accepted = 0;
    do_reset();
    hold_empty = 1'b0;
    m_ready = 1'b1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 72000 && accepted < 70000; cyc++) begin
      while (wr_cnt - rd_cnt < 64) push_word(8'(wr_cnt), 1'b0);
      #1;
      if (m_valid && m_ready) accepted++;
      @(negedge clk);
    end
    m_ready = 1'b0;
    #1;
    checks++; if (accepted != 70000) begin errors++; $display("FAIL cnt_timeout: got %0d accepted expected 70000", accepted); end
    checks++; if (word_count !== 16'd4464) begin errors++; $display("FAIL cnt_value: got %0d expected 4464", word_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_empty_rise();
    test_reset_mid();
`ifdef FIFO_RD_STREAM_CNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
